fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the 9-bit BaLuGa core.
- Drives the address of the combinational instruction ROM and latches the returned word into an instruction register. Presents that word to the decode/execute datapath.
- Advances or redirects the PC on branches, and stops on the halt encoding. Sits between the instruction ROM and the decode stage.

Parameters:
ADDR_W, 8, PC / ROM address width
INSTR_W, 9, instruction word width
START_PC, 0, PC value after reset and on each start
HALT_WORD, 9'b0111_00_010, encoding that ends the program

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin execution from START_PC; sampled only in IDLE or HALTED
stall  input  1  datapath not ready; holds EXEC
rom_address  output  ADDR_W  address to instruction ROM
rom_instruction  input  INSTR_W  ROM data, combinational from rom_address
instruction  output  INSTR_W  instruction register contents
instr_valid  output  1  instruction is valid for execute
branch_taken  input  1  datapath branch decision for the current instruction
branch_offset  input  ADDR_W  signed two's-complement PC displacement (datapath $branch)
pc  output  ADDR_W  address of the current instruction
halted  output  1  program has finished
done  output  1  one-cycle pulse on entry to HALTED

Behaviour:
- Reset is asynchronous, active-low. Values on reset:
  - state=IDLE, pc=START_PC, instruction=0.
  - instr_valid=0, halted=0, done=0.
  - rom_address=pc.
- rom_address = pc at all times (combinational).
- IDLE:
  - start=1 -> FETCH, with pc=START_PC.
- FETCH (1 cycle):
  - instruction <= rom_instruction.
  - Next state is EXEC.
- EXEC:
  - instr_valid=1.
  - stall=1: hold pc, instruction and state.
  - stall=0 and instruction==HALT_WORD: go to HALTED. pc is not advanced, and done=1 for the first HALTED cycle only.
  - stall=0 and branch_taken=1: pc <= pc + branch_offset (sign-extended, modulo 2^ADDR_W), then FETCH.
  - stall=0 otherwise: pc <= pc + 1 (modulo 2^ADDR_W), then FETCH.
- Throughput: two cycles per instruction when there is no stall.
- branch_taken and branch_offset are sampled only in EXEC with stall=0. They are ignored in every other state.
- HALTED:
  - halted=1 and instr_valid=0. pc and instruction are held.
  - start=1 -> pc=START_PC and go to FETCH. halted clears on the next cycle.
- start is ignored in FETCH and EXEC.
- PC wrap: 255+1 -> 0. A branch from 2 with offset 0xF0 gives 0xF2. No fault is raised.
- A branch offset of 0 refetches the same address. This is legal and gives a spin loop.
- Reset asserted mid-instruction returns to IDLE immediately. No done pulse is generated.

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- When defined:
  - Adds input port `step` (1 bit).
  - EXEC leaves only on a cycle with stall=0 and step=1. step is a one-instruction advance, level-sampled, so the bench pulses it for one cycle.
  - Halt detection and done behave the same, but also wait for step.
- When undefined: no `step` port, and behaviour is as described above.

Decomposition:
- Shared package `baluga_pkg`:
  - ADDR_W and INSTR_W constants.
  - HALT_WORD constant.
  - Opcode field slice positions: [8:5] opcode, [4:3] reg, [2:0] reg/imm.
  - Sequencer state enum: IDLE, FETCH, EXEC, HALTED.
- Single module; no sub-module is needed. The PC adder is inline.

Test Plan:
- Reset then start with a ROM model holding linear words 0..5 and HALT at 6:
  - rom_address steps 0,1,...,6, with instr_valid high every second cycle.
  - done pulses once at the 14th cycle after start; halted stays 1 and pc=6.
- Branch back: at pc=36, branch_taken=1 and offset=8'hE3 (-29):
  - next rom_address=7 and instruction=ROM[7].
  - then a non-taken advance to 8.
- stall held for 3 cycles in EXEC at pc=12:
  - instruction and pc are unchanged and instr_valid stays 1.
  - FETCH of 13 occurs on the cycle after stall drops.
- Wrap: ROM has no HALT and pc reaches 255 with no branch -> next pc=0. Taken branch at pc=250 with offset=+10 -> pc=4.
- reset_n asserted in EXEC at pc=20 -> pc=0, state IDLE, instr_valid=0, done never pulses. start afterwards fetches address 0.
- HALTED then start=1 -> refetch from START_PC; halted clears and done does not pulse again until the next HALT.

Source files
------------

// File: rtl/baluga_pkg.sv
// Shared BaLuGa core definitions: word widths, halt encoding, instruction field
// positions and the fetch sequencer state encoding.
package baluga_pkg;

  localparam int BALUGA_ADDR_W  = 8;
  localparam int BALUGA_INSTR_W = 9;

  localparam logic [BALUGA_INSTR_W-1:0] BALUGA_HALT_WORD = 9'b0111_00_010;

  // Instruction field slices: [8:5] opcode, [4:3] reg, [2:0] reg/imm
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam int REG_HI = 4;
  localparam int REG_LO = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [BALUGA_INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// PC and fetch controller: FETCH latches the ROM word, EXEC holds it for the
// datapath and then advances, branches or halts. Optional macro: FETCH_SINGLE_STEP_EN.
module fetch_sequencer
  import baluga_pkg::*;
#(
  parameter int                 ADDR_W    = BALUGA_ADDR_W,
  parameter int                 INSTR_W   = BALUGA_INSTR_W,
  parameter logic [ADDR_W-1:0]  START_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = BALUGA_HALT_WORD
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               done
);

  seq_state_t         state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, pc_nxt;
  logic [INSTR_W-1:0] ir_q, ir_nxt;
  logic               done_q, done_nxt;
  logic               advance;
  logic               is_halt;

`ifdef FETCH_SINGLE_STEP_EN
  assign advance = ~stall & step;
`else
  assign advance = ~stall;
`endif

  assign is_halt = (ir_q == HALT_WORD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc_q   <= START_PC;
      ir_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      ir_q   <= ir_nxt;
      done_q <= done_nxt;
    end
  end

  // Halt outranks a branch; same-width add gives sign extension and wrap for free.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = START_PC;
        end
      end
      FETCH: begin
        ir_nxt    = rom_instruction;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (advance) begin
          if (is_halt) begin
            state_nxt = HALTED;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = branch_taken ? (pc_q + branch_offset) : (pc_q + ADDR_W'(1));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rom_address = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALTED);
  assign done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table-driven linear program to HALT, then
// hand sequences for restart, branches, stall, wrap and mid-instruction reset.
module tb_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, stall, branch_taken;
  logic [7:0] branch_offset;
  logic [7:0] rom_address, pc;
  logic [8:0] rom_instruction, instruction;
  logic       instr_valid, halted, done;

  logic [8:0] rom [256];
  localparam logic [8:0] HALT = 9'b0111_00_010;

  int n_cmp = 0;
  int n_bad = 0;

  assign rom_instruction = rom[rom_address];

  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .rom_address(rom_address), .rom_instruction(rom_instruction),
    .instruction(instruction), .instr_valid(instr_valid),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .halted(halted), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic       bt;
    logic [7:0] off;
    logic [7:0] e_pc;
    logic [8:0] e_instr;
    logic       e_valid;
    logic       e_halted;
    logic       e_done;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] o,
                              input logic [7:0] p, input logic [8:0] i,
                              input logic v, input logic h, input logic d);
    vec_t r;
    r.start = s; r.bt = b; r.off = o; r.e_pc = p; r.e_instr = i;
    r.e_valid = v; r.e_halted = h; r.e_done = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called in EXEC: resolve it, check the FETCH cycle, then the following EXEC.
  task automatic go(input logic bt, input logic [7:0] off, input logic [7:0] exp_pc, input string nm);
    branch_taken  = bt;
    branch_offset = off;
    tick();
    chk({nm, "_fetch_pc"}, 32'(pc), 32'(exp_pc));
    chk({nm, "_fetch_addr"}, 32'(rom_address), 32'(exp_pc));
    chk({nm, "_fetch_valid"}, 32'(instr_valid), 32'd0);
    // branch inputs must be ignored outside EXEC
    branch_taken  = 1'b1;
    branch_offset = 8'h55;
    tick();
    branch_taken  = 1'b0;
    branch_offset = 8'h00;
    chk({nm, "_exec_valid"}, 32'(instr_valid), 32'd1);
    chk({nm, "_exec_pc"}, 32'(pc), 32'(exp_pc));
    chk({nm, "_exec_instr"}, 32'(instruction), 32'(rom[exp_pc]));
  endtask

  initial begin
    int cnt, at, done_seen;

    reset_n = 1'b0; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = {1'b1, 8'(i)};
    for (int i = 0; i < 6; i++) rom[i] = 9'(i);
    rom[6] = HALT;

    // Linear program: odd rows applied in FETCH, even rows (>=2) in EXEC.
    tbl[0]  = mk(1, 0, 8'h00, 0, 9'd0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h40, 0, 9'd0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 8'h00, 1, 9'd0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 8'h00, 1, 9'd1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 2, 9'd1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 2, 9'd2, 1, 0, 0);
    tbl[6]  = mk(0, 0, 8'h00, 3, 9'd2, 0, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 3, 9'd3, 1, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 4, 9'd3, 0, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 4, 9'd4, 1, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 5, 9'd4, 0, 0, 0);
    tbl[11] = mk(0, 0, 8'h00, 5, 9'd5, 1, 0, 0);
    tbl[12] = mk(0, 0, 8'h00, 6, 9'd5, 0, 0, 0);
    tbl[13] = mk(0, 0, 8'h00, 6, HALT, 1, 0, 0);
    tbl[14] = mk(0, 1, 8'h05, 6, HALT, 0, 1, 1);
    tbl[15] = mk(0, 0, 8'h00, 6, HALT, 0, 1, 0);

    #12;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_addr", 32'(rom_address), 32'd0);
    chk("reset_instr", 32'(instruction), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_valid", 32'(instr_valid), 32'd0);

    for (int r = 0; r < 16; r++) begin
      start = tbl[r].start; branch_taken = tbl[r].bt; branch_offset = tbl[r].off;
      tick();
      chk($sformatf("row%0d_pc", r), 32'(pc), 32'(tbl[r].e_pc));
      chk($sformatf("row%0d_addr", r), 32'(rom_address), 32'(tbl[r].e_pc));
      chk($sformatf("row%0d_instr", r), 32'(instruction), 32'(tbl[r].e_instr));
      chk($sformatf("row%0d_valid", r), 32'(instr_valid), 32'(tbl[r].e_valid));
      chk($sformatf("row%0d_halted", r), 32'(halted), 32'(tbl[r].e_halted));
      chk($sformatf("row%0d_done", r), 32'(done), 32'(tbl[r].e_done));
    end
    start = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00;

    // Restart from HALTED: halted clears at once, done pulses exactly once on re-halt.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_halted_clear", 32'(halted), 32'd0);
    chk("rerun_pc", 32'(pc), 32'd0);
    chk("rerun_done0", 32'(done), 32'd0);
    cnt = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin cnt++; at = i; end
    end
    chk("rerun_done_count", 32'(cnt), 32'd1);
    chk("rerun_done_cycle", 32'(at), 32'd14);
    chk("rerun_halted", 32'(halted), 32'd1);
    chk("rerun_pc_held", 32'(pc), 32'd6);

    // Branch / stall / wrap program: no HALT anywhere.
    for (int i = 0; i < 256; i++) rom[i] = {1'b1, 8'(i)};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("br_start_instr", 32'(instruction), 32'(rom[0]));
    go(1'b1, 8'd36,  8'd36, "br_to36");
    go(1'b1, 8'hE3,  8'd7,  "br_back7");
    go(1'b0, 8'hE3,  8'd8,  "adv8");
    go(1'b1, 8'd4,   8'd12, "br_to12");

    // Stall 3 cycles in EXEC at 12 with start and a branch request present.
    stall = 1'b1; start = 1'b1; branch_taken = 1'b1; branch_offset = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_pc", i), 32'(pc), 32'd12);
      chk($sformatf("stall%0d_instr", i), 32'(instruction), 32'(rom[12]));
      chk($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
    end
    stall = 1'b0; start = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00;
    tick();
    chk("unstall_pc", 32'(pc), 32'd13);
    chk("unstall_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("unstall_instr", 32'(instruction), 32'(rom[13]));

    go(1'b1, 8'hED, 8'd250, "br_to250");
    go(1'b1, 8'd10, 8'd4,   "wrap_br");
    go(1'b1, 8'hFB, 8'd255, "br_to255");
    go(1'b0, 8'h00, 8'd0,   "wrap_inc");
    go(1'b0, 8'h00, 8'd1,   "adv1");
    go(1'b0, 8'h00, 8'd2,   "adv2");
    go(1'b1, 8'hF0, 8'hF2,  "br_f0");
    go(1'b1, 8'h00, 8'hF2,  "spin");
    go(1'b1, 8'h22, 8'd20,  "br_to20");

    // Asynchronous reset in EXEC at pc=20.
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin #2; reset_n = 1'b1; end
      tick();
      if (done || instr_valid || pc != 8'd0) done_seen++;
    end
    chk("midrst_idle_quiet", 32'(done_seen), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_addr", 32'(rom_address), 32'd0);
    chk("post_rst_fetch_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(instr_valid), 32'd1);
    chk("post_rst_instr", 32'(instruction), 32'(rom[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
